irq_controller: RTL and testbench

- Interrupt controller that sits directly upstream of the BWZZ processor top and drives its single `interrupt` input.
- Captures rising edges on NUM_SRC external request lines into a pending register and applies a software mask.
- Selects the highest-priority pending, unmasked source (lowest index wins) and issues a one-cycle interrupt pulse with a latched vector index.
- Blocks further pulses until the processor signals return-from-interrupt, then waits a fixed cool-down so the pipeline can refill.

---
 rtl/bwzz_pkg.sv | 14 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_controller.sv | 122 ++++++++++++
 tb/tb_irq_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bwzz_pkg.sv
// Shared definitions for the interrupt controller that feeds the BWZZ processor.
// State encoding and the default cool-down length live here.
package bwzz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SIGNAL   = 2'd1,
    ST_WAIT_RTI = 2'd2,
    ST_COOLDOWN = 2'd3
  } irq_state_t;

  localparam int COOLDOWN_DEFAULT = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request bit as an index plus a valid flag.
module irq_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [VEC_W-1:0]   idx,
  output logic               valid
);

  // Scan from the top down so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = VEC_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-capturing, maskable, fixed-priority interrupt controller issuing one pulse per service
// and holding off new pulses until rti plus a cool-down.
module irq_controller
  import bwzz_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int VEC_W    = 2,
  parameter int COOLDOWN = COOLDOWN_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               rti,
  output logic               interrupt,
  output logic [VEC_W-1:0]   vector,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  localparam int CNT_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  irq_state_t         state_reg, state_next;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg, mask_next;
  logic [NUM_SRC-1:0] irq_q;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               interrupt_reg, interrupt_next;
  logic [VEC_W-1:0]   vector_reg, vector_next;
  logic               in_service_reg, in_service_next;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic [VEC_W-1:0]   sel_idx;
  logic               sel_valid;

  assign rise     = irq & ~irq_q;
  assign eligible = pending_reg & mask_reg;

  irq_prio_enc #(
    .NUM_SRC(NUM_SRC),
    .VEC_W  (VEC_W)
  ) u_prio (
    .req  (eligible),
    .idx  (sel_idx),
    .valid(sel_valid)
  );

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    vector_next     = vector_reg;
    interrupt_next  = 1'b0;
    in_service_next = in_service_reg;
    clr             = '0;
    case (state_reg)
      ST_IDLE: begin
        if (sel_valid) begin
          vector_next     = sel_idx;
          interrupt_next  = 1'b1;
          in_service_next = 1'b1;
          clr             = NUM_SRC'(1) << sel_idx;
          state_next      = ST_SIGNAL;
        end
      end
      ST_SIGNAL: state_next = ST_WAIT_RTI;
      ST_WAIT_RTI: begin
        if (rti) begin
          in_service_next = 1'b0;
          if (COOLDOWN == 0) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next   = CNT_W'(COOLDOWN);
            state_next = ST_COOLDOWN;
          end
        end
      end
      ST_COOLDOWN: begin
        if (cnt_reg <= CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A fresh rise on the bit being cleared keeps it pending.
    pending_next = (pending_reg & ~clr) | rise;
    mask_next    = mask_we ? mask_wdata : mask_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      pending_reg    <= '0;
      mask_reg       <= '1;
      irq_q          <= '0;
      cnt_reg        <= '0;
      interrupt_reg  <= 1'b0;
      vector_reg     <= '0;
      in_service_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      mask_reg       <= mask_next;
      irq_q          <= irq;
      cnt_reg        <= cnt_next;
      interrupt_reg  <= interrupt_next;
      vector_reg     <= vector_next;
      in_service_reg <= in_service_next;
    end
  end

  assign interrupt  = interrupt_reg;
  assign vector     = vector_reg;
  assign in_service = in_service_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios then random traffic,
// all compared each cycle against a timestamp-style behavioural model.
module tb_irq_controller;

  localparam int NUM_SRC  = 4;
  localparam int VEC_W    = 2;
  localparam int COOLDOWN = 3;

  logic               clk;
  logic               reset;
  logic [NUM_SRC-1:0] irq;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               rti;
  logic               interrupt;
  logic [VEC_W-1:0]   vector;
  logic               in_service;
  logic [NUM_SRC-1:0] pending;

  irq_controller #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W),
    .COOLDOWN(COOLDOWN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .rti       (rti),
    .interrupt (interrupt),
    .vector    (vector),
    .in_service(in_service),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Model: requests, mask, last irq, and service status expressed as
  // "busy" plus a count of edges to wait before the next pick is allowed.
  logic [NUM_SRC-1:0] m_pend, m_mask, m_prev;
  logic [VEC_W-1:0]   m_vec;
  bit                 m_int, m_svc;
  int                 m_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '1; m_prev = '0; m_vec = '0;
    m_int = 0; m_svc = 0; m_hold = 0;
  endtask

  task automatic model_edge();
    logic [NUM_SRC-1:0] elig, onehot, rise, clr;
    bit was_pulse;
    elig      = m_pend & m_mask;
    rise      = irq & ~m_prev;
    was_pulse = m_int;
    clr       = '0;
    m_int     = 0;
    if (!m_svc && m_hold == 0 && elig != 0) begin
      onehot = elig & (~elig + 1'b1);
      m_vec  = VEC_W'($clog2(onehot));
      m_int  = 1;
      m_svc  = 1;
      clr    = onehot;
    end else if (m_svc && !was_pulse && rti) begin
      m_svc  = 0;
      m_hold = COOLDOWN;
    end else if (!m_svc && m_hold > 0) begin
      m_hold--;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (mask_we) m_mask = mask_wdata;
    m_prev = irq;
  endtask

  task automatic check_outputs();
    chk("interrupt", 32'(interrupt), 32'(m_int));
    chk("vector", 32'(vector), 32'(m_vec));
    chk("in_service", 32'(in_service), 32'(m_svc));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic step(input logic [NUM_SRC-1:0] i, input logic we,
                      input logic [NUM_SRC-1:0] wd, input logic r);
    @(negedge clk);
    irq = i; mask_we = we; mask_wdata = wd; rti = r;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    if (interrupt) pulses++;
    $display("step irq=%b we=%b wd=%b rti=%b -> int=%b vec=%0d svc=%b pend=%b",
             i, we, wd, r, interrupt, vector, in_service, pending);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    irq = '0; mask_we = 0; mask_wdata = '0; rti = 0;
    #1;
    model_reset();
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    chk("rst_vector", 32'(vector), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int k;

  initial begin
    reset = 1'b1; irq = '0; mask_we = 0; mask_wdata = '0; rti = 0;
    model_reset();
    #1;
    chk("por_interrupt", 32'(interrupt), 32'd0);
    chk("por_pending", 32'(pending), 32'd0);
    #20;
    @(negedge clk);
    reset = 1'b0;

    // Single rise on irq[2]
    step(4'b0100, 0, 0, 0);
    chk("t1_pending_set", 32'(pending), 32'h4);
    chk("t1_no_pulse_yet", 32'(interrupt), 32'd0);
    step(4'b0100, 0, 0, 0);
    chk("t1_pulse", 32'(interrupt), 32'd1);
    chk("t1_vector", 32'(vector), 32'd2);
    chk("t1_pending_clr", 32'(pending), 32'd0);
    step(4'b0000, 0, 0, 0);
    chk("t1_pulse_one_cycle", 32'(interrupt), 32'd0);
    chk("t1_svc_held", 32'(in_service), 32'd1);
    step(4'b0000, 0, 0, 1);
    chk("t1_svc_drop", 32'(in_service), 32'd0);
    repeat (4) step(4'b0000, 0, 0, 0);

    // Simultaneous rises on irq[3] and irq[1]
    step(4'b1010, 0, 0, 0);
    step(4'b1010, 0, 0, 0);
    chk("t2_first_vec", 32'(vector), 32'd1);
    chk("t2_keep3", 32'(pending), 32'h8);
    step(4'b1010, 0, 0, 0);
    step(4'b1010, 0, 0, 1);
    for (k = 1; k <= COOLDOWN + 1; k++) begin
      step(4'b0000, 0, 0, 0);
      chk("t2_second_timing", 32'(interrupt), 32'(k == COOLDOWN + 1));
    end
    chk("t2_second_vec", 32'(vector), 32'd3);
    step(4'b0000, 0, 0, 0);
    step(4'b0000, 0, 0, 1);
    repeat (4) step(4'b0000, 0, 0, 0);

    // Masked source is retained and fires once unmasked
    step(4'b0000, 1, 4'b1110, 0);
    step(4'b0001, 0, 0, 0);
    repeat (3) step(4'b0001, 0, 0, 0);
    chk("t3_masked_pending", 32'(pending), 32'h1);
    chk("t3_masked_svc", 32'(in_service), 32'd0);
    step(4'b0001, 1, 4'b1111, 0);
    step(4'b0001, 0, 0, 0);
    chk("t3_unmask_pulse", 32'(interrupt), 32'd1);
    chk("t3_unmask_vec", 32'(vector), 32'd0);
    step(4'b0000, 0, 0, 0);
    step(4'b0000, 0, 0, 1);
    repeat (4) step(4'b0000, 0, 0, 0);

    // Level held for 20 cycles yields one pulse; stray rti is ignored
    pulses = 0;
    for (k = 0; k < 20; k++) step(4'b0010, 0, 0, (k == 3) || (k > 8 && k[0]));
    chk("t4_one_pulse", 32'(pulses), 32'd1);
    chk("t4_idle_svc", 32'(in_service), 32'd0);
    step(4'b0000, 0, 0, 0);

    // Rise during WAIT_RTI waits for rti plus cool-down
    step(4'b0100, 0, 0, 0);
    step(4'b0100, 0, 0, 0);
    step(4'b0101, 0, 0, 0);
    pulses = 0;
    repeat (5) step(4'b0101, 0, 0, 0);
    chk("t5_no_nesting", 32'(pulses), 32'd0);
    step(4'b0101, 0, 0, 1);
    for (k = 1; k <= COOLDOWN + 1; k++) begin
      step(4'b0000, 0, 0, 0);
      chk("t5_cooldown_timing", 32'(interrupt), 32'(k == COOLDOWN + 1));
    end
    chk("t5_vec", 32'(vector), 32'd0);
    step(4'b0000, 0, 0, 0);
    step(4'b0000, 0, 0, 1);
    repeat (4) step(4'b0000, 0, 0, 0);

    // Reset during WAIT_RTI with pending 0110
    step(4'b0001, 0, 0, 0);
    step(4'b0001, 0, 0, 0);
    step(4'b0111, 0, 0, 0);
    step(4'b0111, 0, 0, 0);
    chk("t6_pending_before", 32'(pending), 32'h6);
    chk("t6_svc_before", 32'(in_service), 32'd1);
    do_reset();
    pulses = 0;
    repeat (8) step(4'b0000, 0, 0, 0);
    chk("t6_no_pulse_after", 32'(pulses), 32'd0);

    // Random traffic
    pulses = 0;
    for (int n = 0; n < 600; n++) begin
      logic [NUM_SRC-1:0] ni, nw;
      logic nwe, nr;
      ni  = ($urandom_range(0, 3) == 0) ? NUM_SRC'($urandom) : irq;
      nwe = ($urandom_range(0, 15) == 0);
      nw  = ($urandom_range(0, 2) == 0) ? NUM_SRC'($urandom) : '1;
      nr  = ($urandom_range(0, 3) == 0);
      step(ni, nwe, nw, nr);
    end
    checks++;
    assert (pulses > 10) else begin
      errors++;
      $error("FAIL rand_activity observed=%0d expected=>10", pulses);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
